// File: rtl/mul_seq_pkg.sv
// ============================================================================
//  Module   : mul_seq_pkg
//  Brief    : Shared types and constants for the radix-4 Booth multiply slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

   localparam int c_DEF_WIDTH = 32;
   localparam int c_DEF_STEPS = c_DEF_WIDTH / 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      M1   = 3'd3,
      M2   = 3'd4
   } booth_dig_e;

   // Window is {Q[1], Q[0], q-1}.
   function automatic booth_dig_e booth_recode(input logic [2:0] win);
      booth_dig_e dig;
      case (win)
         3'b001, 3'b010: dig = P1;
         3'b011:         dig = P2;
         3'b100:         dig = M2;
         3'b101, 3'b110: dig = M1;
         default:        dig = ZERO;
      endcase
      return dig;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_ctrl_if.sv
// ============================================================================
//  Module   : mul_seq_ctrl_if
//  Brief    : Start/ready request and HI/LO result bundle for mul_seq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul_seq_ctrl_if
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, op_a, op_b, abort,
      input  ready, busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op_a, op_b, abort,
      output ready, busy, done, hi_out, lo_out
   );
endinterface

`default_nettype wire

// File: rtl/booth_r4_sel.sv
// ============================================================================
//  Module   : booth_r4_sel
//  Brief    : Radix-4 Booth partial-product selector (0, +-M, +-2M).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_r4_sel
   import mul_seq_pkg::*;
#(
   parameter int PW = 2 * c_DEF_WIDTH
) (
   input  wire logic [2:0]    i_win,
   input  wire logic [PW-1:0] i_m,
   output logic      [PW-1:0] o_pp
);

   always_comb begin
      o_pp = '0;
      case (booth_recode(i_win))
         P1:      o_pp = i_m;
         P2:      o_pp = i_m << 1;
         M1:      o_pp = -i_m;
         M2:      o_pp = -(i_m << 1);
         default: o_pp = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
//  Module   : mul_seq_ctrl
//  Brief    : Sequential radix-4 Booth signed multiplier controller for HI/LO.
//             Optional early-out on constant remaining multiplier bits:
//             MULSEQ_EARLY_TERM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH
) (
   input  wire logic     clk,
   input  wire logic     clr,
   mul_seq_ctrl_if.slave bus
);

   localparam int             STEPS  = WIDTH / 2;
   localparam int             PW     = 2 * WIDTH;
   localparam int             CW     = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0]  c_LAST = CW'(STEPS - 1);

   state_e                  r_state;
   state_e                  w_state_next;
   logic [PW-1:0]           r_m;
   logic [PW-1:0]           r_p;
   logic [PW-1:0]           w_pp;
   logic [PW-1:0]           w_p_sum;
   logic signed [WIDTH-1:0] r_q;
   logic signed [WIDTH-1:0] w_q_next;
   logic                    r_qm1;
   logic [CW-1:0]           r_cnt;
   logic [WIDTH-1:0]        r_hi;
   logic [WIDTH-1:0]        r_lo;
   logic                    w_ready;
   logic                    w_busy;
   logic                    w_done;
   logic                    w_accept;
   logic                    w_last;

   assign w_q_next = r_q >>> 2;
   assign w_p_sum  = r_p + w_pp;

`ifdef MULSEQ_EARLY_TERM_EN
   // Once the unconsumed multiplier bits are all equal, every later digit is 0.
   logic [WIDTH:0] w_rest;
   assign w_rest = {w_q_next, r_q[1]};
   assign w_last = (r_cnt == c_LAST) || (w_rest == '0) || (&w_rest);
`else
   assign w_last = (r_cnt == c_LAST);
`endif

   booth_r4_sel #(
      .PW (PW)
   ) u_sel (
      .i_win ({r_q[1:0], r_qm1}),
      .i_m   (r_m),
      .o_pp  (w_pp)
   );

   always_ff @(posedge clk) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready  = !clr;
            w_accept = bus.start && !bus.abort;
            if (w_accept) w_state_next = RUN;
         end
         RUN: begin
            w_busy = 1'b1;
            if (bus.abort)   w_state_next = IDLE;
            else if (w_last) w_state_next = DONE;
         end
         DONE: begin
            w_ready      = !clr;
            w_done       = 1'b1;
            w_accept     = bus.start && !bus.abort;
            w_state_next = w_accept ? RUN : IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_m   <= '0;
         r_p   <= '0;
         r_q   <= '0;
         r_qm1 <= 1'b0;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (w_accept) begin
         r_m   <= {{WIDTH{bus.op_a[WIDTH-1]}}, bus.op_a};
         r_p   <= '0;
         r_q   <= $signed(bus.op_b);
         r_qm1 <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == RUN && !bus.abort) begin
         r_p   <= w_p_sum;
         r_m   <= r_m << 2;
         r_qm1 <= r_q[1];
         r_q   <= w_q_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) {r_hi, r_lo} <= w_p_sum;
      end
   end

   assign bus.ready  = w_ready;
   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.hi_out = r_hi;
   assign bus.lo_out = r_lo;

endmodule

`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential radix-4 Booth multiply controller for the CPU's HI/LO multiply path. It accepts a signed 32×32 multiply through a start/ready handshake. It retires one Booth digit per clock over 16 steps and presents a signed 64-bit product on HI/LO with a one-cycle done pulse. The control unit stalls on `busy` and writes HI/LO on `done`.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits; WIDTH must be even
- STEPS, WIDTH/2, Booth radix-4 steps per operation (derived, not overridden)
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  request; accepted on an edge where `ready`=1
- op_a  in  WIDTH  multiplicand, signed
- op_b  in  WIDTH  multiplier, signed
- abort  in  1  cancel an in-flight operation
- ready  out  1  can accept `start` (IDLE or DONE and `clr`=0)
- busy  out  1  RUN state
- done  out  1  one-cycle pulse; product valid
- hi_out  out  WIDTH  product bits [63:32]
- lo_out  out  WIDTH  product bits [31:0]

## Operation
- States: IDLE, RUN, DONE.
- Reset (`clr`=1 at an edge):
  - state→IDLE, step count 0.
  - hi_out, lo_out, internal accumulator, multiplicand and multiplier registers all 0.
  - done=0, busy=0, ready=0 while `clr` is high.
- Start is accepted in IDLE or DONE with `start`=1 and `abort`=0:
  - multiplicand register M ← sign-extend(op_a) to 64 bits
  - multiplier register Q ← op_b; guard bit q₋₁ ← 0
  - accumulator P ← 0; count ← 0; state→RUN
- Each RUN edge:
  - Recode r = {Q[1], Q[0], q₋₁}:
    - 000 and 111 → 0
    - 001 and 010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101 and 110 → −M
  - P ← P + pp, modulo 2⁶⁴.
  - M ← M<<2; q₋₁ ← Q[1]; Q ← Q>>>2 (arithmetic shift); count ← count+1.
- Termination: on the edge with count=STEPS−1, state→DONE and {hi_out, lo_out} ← final P, the same edge's sum.
- DONE lasts one cycle with done=1. The next edge goes to IDLE unless a new start is accepted, in which case it goes to RUN.
- hi_out/lo_out change only at completion or reset. They hold the last product through later RUN cycles and aborts.
- Abort:
  - `abort`=1 in RUN → IDLE on the next edge; no done; P discarded; hi_out/lo_out unchanged.
  - `abort` is ignored in IDLE and DONE, but it blocks a same-cycle `start`.
- Priority: clr > abort > start.
- `start` in RUN is ignored and not queued.

## Timing
- E0 accepts start. E1..E16 perform steps 0..15. At E16 the state goes to DONE and HI/LO update. done is high between E16 and E17.
- Latency: 16 clocks from the start edge to the product edge.
- Back-to-back throughput: 17 clocks per operation when start is accepted in DONE.
- busy is high for exactly 16 cycles per completed operation.
- ready is combinational from state and clr. done and busy are registered state decodes.
- `clr` asserted mid-RUN: IDLE next edge, outputs 0, no done.

## Configuration
- `MULSEQ_EARLY_TERM_EN` defined:
  - After each RUN step, the post-step remaining bits {Q_next, q₋₁_next} are checked.
  - If they are all zeros or all ones, every remaining digit recodes to 0. The block then goes to DONE on that edge and writes HI/LO with P.
  - Latency becomes 1–16 clocks. busy length varies accordingly.
- Undefined: fixed 16-step latency. No early-out logic is synthesized.
- The product must be identical in both builds.

## Structure
- Package `mul_seq_pkg`:
  - state enum (IDLE, RUN, DONE)
  - Booth recode digit constants (ZERO, P1, P2, M1, M2)
  - WIDTH default and STEPS
- Sub-module `booth_r4_sel`:
  - combinational
  - inputs: 3-bit window and 64-bit M
  - output: 64-bit partial product (0, ±M, ±2M)
- The FSM, registers and accumulator stay in `mul_seq_ctrl`.

## Test plan
- a=7, b=6, start at E0 → done during cycle E16–E17, {hi,lo}=0x00000000_0000002A, busy high 16 cycles.
- a=0xFFFFFFFF (−1), b=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFF. Then a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
- After the 0x2A result, start a=3, b=5, then abort at the 5th RUN cycle → no done, hi/lo stay 0x0/0x2A, ready=1 next cycle.
- Start held high in the DONE cycle with a=−2, b=3 → accepted without an IDLE gap; {hi,lo}=0xFFFFFFFF_FFFFFFFA 16 clocks later.
- `clr` pulsed at the 8th RUN cycle → next edge IDLE, hi/lo=0, done never asserts; a new start=1 with clr=0 is accepted afterwards.
- Early-termination product checks:
  - b=0 → product 0.
  - b=3, a=9 → product 27.
- Early-termination latency checks:
  - With `MULSEQ_EARLY_TERM_EN`: done 1 clock after the start edge for b=0, and 2 clocks after for b=3.
  - Without the macro: 16 clocks for both.
